reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Eight-entry circular reorder buffer that sits directly downstream of the CDB arbiter. It allocates a ROB tag per instruction at dispatch and captures each CDB broadcast (tag, result, branch outcome) into the addressed entry. It retires completed entries strictly in program order, one per cycle, to the register file. On retirement of a mispredicted branch it squashes all younger entries and issues a one-cycle flush with the redirect address to fetch.

## Interface
Parameters:
- WIDTH, 31, MSB of data and address words (32-bit).
- ROB, 2, MSB of the ROB tag; entry count is 2^(ROB+1) = 8.
- REG, 4, MSB of the architectural register index (32 registers).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous, active-low; clear==0 at a rising edge resets the block.
- dispatchValid  in  1  dispatch stage presents an instruction.
- dispatchRd  in  REG+1  destination register; 0 = no register write.
- dispatchReady  out  1  an entry is free (count < 8) and flush is low.
- dispatchRob  out  ROB+1  tag that the next allocation receives (tail pointer).
- cdbValid  in  1  CDB broadcast valid this cycle.
- cdbRob  in  ROB+1  tag of the broadcast result.
- cdbResult  in  WIDTH+1  result value; for branches, the link value.
- cdbMispredict  in  1  broadcast is a branch that mispredicted.
- cdbTarget  in  WIDTH+1  correct target address of a mispredicted branch.
- srcRob  in  ROB+1  operand lookup tag.
- srcReady  out  1  looked-up entry has a value available.
- srcValue  out  WIDTH+1  looked-up value.
- commitValid  out  1  head entry retires at this edge.
- commitRd  out  REG+1  head destination register.
- commitValue  out  WIDTH+1  head result.
- commitRob  out  ROB+1  head tag.
- flush  out  1  pipeline squash, registered, high for one cycle.
- redirectPC  out  WIDTH+1  fetch redirect address, valid while flush is high.

## Operation
- Per-entry state: valid, done, mispredict, rd, value, target. Pointers head and tail are ROB+1 bits wide and wrap modulo 8. The occupancy count is ROB+2 bits wide (range 0..8).
- **Allocate** when dispatchValid && dispatchReady. The entry at tail is set to valid=1, done=0, mispredict=0, rd=dispatchRd. Then tail increments.
- **Writeback** when cdbValid and entry[cdbRob].valid. The entry takes done=1, value=cdbResult, mispredict=cdbMispredict, target=cdbTarget. A broadcast to an invalid entry is ignored.
- **Commit** outputs are combinational from head. commitValid = entry[head].valid && entry[head].done. At the edge where commitValid is high, the entry becomes invalid and head increments.
- **Mispredict retire**: when commitValid is high and entry[head].mispredict is set, the edge performs the following:
  - all entries become invalid;
  - head = tail = 0 and count = 0;
  - flush is set to 1 and redirectPC is set to entry[head].target.
  
  A dispatch or CDB write at that same edge is discarded. flush returns to 0 at the following edge.
- **Lookup** (combinational):
  - If entry[srcRob] is valid and done, srcReady=1 and srcValue=entry value.
  - Otherwise, if cdbValid && cdbRob==srcRob, srcReady=1 and srcValue=cdbResult (bypass).
  - Otherwise srcReady=0 and srcValue=0.
- **Count update**: +1 on allocate only, −1 on commit only, unchanged when both occur.

## Timing
- **Reset values**:
  - every entry invalid;
  - head=tail=count=0;
  - flush=0, redirectPC=0;
  - commitValid=0, commitRd=0, commitValue=0, commitRob=0;
  - dispatchReady=1, dispatchRob=0, srcReady=0.
- Reset has priority over every other event. A reset mid-operation discards all entries.
- Minimum latency from allocation (edge E) to retirement:
  - CDB broadcast in the cycle after E is written at edge E+1;
  - commitValid is high in the cycle after E+1;
  - the entry retires at edge E+2.
- A CDB write to the head entry is not visible to commit in the same cycle. commitValid rises one cycle later.
- **Full**: dispatchReady is computed from count before the edge. At count==8 allocation is refused even if a commit occurs at the same edge.
- **Empty**: commitValid=0. Allocation with an immediate CDB hit is not possible in the same cycle.
- Wrap-around: tail 7→0 and head 7→0 operate without gaps. Tags are reused only after retirement.
- dispatchReady=0 during the flush cycle. The first allocation after a flush receives tag 0.

## Test plan
- **Reset and basic retire**:
  - stimulus: clear=0 for 2 cycles; dispatch rd=5; CDB tag 0, result 60;
  - required: dispatchRob=0 at allocation; commitValid with commitRd=5, commitValue=60, commitRob=0 exactly 2 cycles after allocation.
- **Out-of-order writeback**:
  - stimulus: dispatch tags 0,1,2; CDB order 2,1,0 with values 30,20,10;
  - required: retirements in order 0,1,2 with values 10,20,30, one per cycle.
- **Full and wrap**:
  - stimulus: 8 dispatches with no writeback;
  - required: dispatchReady=0 and a 9th dispatch ignored. After completing and retiring tag 0, the next allocation gets tag 0 and count returns to 8.
- **Mispredict flush**:
  - stimulus: tags 0..3 allocated; tag 1 CDB with mispredict=1, target 32'h100; tags 0,2,3 completed;
  - required: tag 0 retires, then tag 1 retires; flush=1 for one cycle with redirectPC=32'h100; tags 2,3 never commit; dispatchRob=0 afterwards.
- **Lookup bypass**:
  - stimulus: srcRob=3 pending, CDB tag 3 value 77 in the same cycle;
  - required: srcReady=1, srcValue=77 that cycle; same result from stored state next cycle.
- **Simultaneous allocate and commit at count 7**:
  - required: count stays 7 and tail and head both advance.

Source files
------------

// File: rtl/reorder_buffer.sv
// Eight-entry circular reorder buffer: allocates tags at dispatch, captures CDB
// results, retires in program order and squashes everything on a mispredicted branch.
module reorder_buffer #(
    parameter int WIDTH = 31,
    parameter int ROB   = 2,
    parameter int REG   = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             dispatchValid,
    input  logic [REG:0]     dispatchRd,
    output logic             dispatchReady,
    output logic [ROB:0]     dispatchRob,
    input  logic             cdbValid,
    input  logic [ROB:0]     cdbRob,
    input  logic [WIDTH:0]   cdbResult,
    input  logic             cdbMispredict,
    input  logic [WIDTH:0]   cdbTarget,
    input  logic [ROB:0]     srcRob,
    output logic             srcReady,
    output logic [WIDTH:0]   srcValue,
    output logic             commitValid,
    output logic [REG:0]     commitRd,
    output logic [WIDTH:0]   commitValue,
    output logic [ROB:0]     commitRob,
    output logic             flush,
    output logic [WIDTH:0]   redirectPC
);

    localparam int DEPTH = 2 ** (ROB + 1);
    localparam logic [ROB+1:0] FULL_COUNT = DEPTH[ROB+1:0];

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] done_r;
    logic [DEPTH-1:0] mis_r;
    logic [REG:0]     rd_r     [DEPTH];
    logic [WIDTH:0]   value_r  [DEPTH];
    logic [WIDTH:0]   target_r [DEPTH];
    logic [ROB:0]     head_r;
    logic [ROB:0]     tail_r;
    logic [ROB+1:0]   count_r;
    logic             flush_r;
    logic [WIDTH:0]   redirect_r;

    logic             ready_s;
    logic             alloc_s;
    logic             commit_s;
    logic             squash_s;
    logic             write_s;

    assign ready_s  = (count_r < FULL_COUNT) && !flush_r;
    assign alloc_s  = dispatchValid && ready_s;
    assign commit_s = valid_r[head_r] && done_r[head_r];
    assign squash_s = commit_s && mis_r[head_r];
    assign write_s  = cdbValid && valid_r[cdbRob];

    assign dispatchReady = ready_s;
    assign dispatchRob   = tail_r;
    assign commitValid   = commit_s;
    assign commitRob     = head_r;
    assign flush         = flush_r;
    assign redirectPC    = redirect_r;

    // Head entry payload, zeroed while nothing is retiring
    always_comb begin
        commitRd    = '0;
        commitValue = '0;
        if (commit_s) begin
            commitRd    = rd_r[head_r];
            commitValue = value_r[head_r];
        end else begin
            commitRd    = '0;
            commitValue = '0;
        end
    end

    // Operand lookup: stored value first, then same-cycle CDB bypass
    always_comb begin
        srcReady = 1'b0;
        srcValue = '0;
        if (valid_r[srcRob] && done_r[srcRob]) begin
            srcReady = 1'b1;
            srcValue = value_r[srcRob];
        end else if (cdbValid && (cdbRob == srcRob)) begin
            srcReady = 1'b1;
            srcValue = cdbResult;
        end else begin
            srcReady = 1'b0;
            srcValue = '0;
        end
    end

    // Entry array: writeback, allocation and retirement; a squash drops all entries
    always_ff @(posedge clk) begin
        if (!clear) begin
            valid_r <= '0;
            done_r  <= '0;
            mis_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]     <= '0;
                value_r[i]  <= '0;
                target_r[i] <= '0;
            end
        end else if (squash_s) begin
            valid_r <= '0;
        end else begin
            // The tail slot is never valid when allocating, so these never collide
            if (write_s) begin
                done_r[cdbRob]   <= 1'b1;
                mis_r[cdbRob]    <= cdbMispredict;
                value_r[cdbRob]  <= cdbResult;
                target_r[cdbRob] <= cdbTarget;
            end
            if (alloc_s) begin
                valid_r[tail_r] <= 1'b1;
                done_r[tail_r]  <= 1'b0;
                mis_r[tail_r]   <= 1'b0;
                rd_r[tail_r]    <= dispatchRd;
            end
            if (commit_s) begin
                valid_r[head_r] <= 1'b0;
            end
        end
    end

    // Pointers, occupancy and the one-cycle flush/redirect
    always_ff @(posedge clk) begin
        if (!clear) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            flush_r    <= 1'b0;
            redirect_r <= '0;
        end else if (squash_s) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
            flush_r    <= 1'b1;
            redirect_r <= target_r[head_r];
        end else begin
            flush_r <= 1'b0;
            if (alloc_s) begin
                tail_r <= tail_r + 1'b1;
            end
            if (commit_s) begin
                head_r <= head_r + 1'b1;
            end
            case ({alloc_s, commit_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        clear;
    logic        dispatchValid;
    logic [4:0]  dispatchRd;
    logic        dispatchReady;
    logic [2:0]  dispatchRob;
    logic        cdbValid;
    logic [2:0]  cdbRob;
    logic [31:0] cdbResult;
    logic        cdbMispredict;
    logic [31:0] cdbTarget;
    logic [2:0]  srcRob;
    logic        srcReady;
    logic [31:0] srcValue;
    logic        commitValid;
    logic [4:0]  commitRd;
    logic [31:0] commitValue;
    logic [2:0]  commitRob;
    logic        flush;
    logic [31:0] redirectPC;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk(clk), .clear(clear),
        .dispatchValid(dispatchValid), .dispatchRd(dispatchRd),
        .dispatchReady(dispatchReady), .dispatchRob(dispatchRob),
        .cdbValid(cdbValid), .cdbRob(cdbRob), .cdbResult(cdbResult),
        .cdbMispredict(cdbMispredict), .cdbTarget(cdbTarget),
        .srcRob(srcRob), .srcReady(srcReady), .srcValue(srcValue),
        .commitValid(commitValid), .commitRd(commitRd),
        .commitValue(commitValue), .commitRob(commitRob),
        .flush(flush), .redirectPC(redirectPC)
    );

    always #5 clk = ~clk;

    // Model: in-flight tags in program order plus per-tag completion data
    int          m_q[$];
    int          m_tail;
    bit          m_init = 1'b0;
    bit          m_flush;
    logic [31:0] m_redir;
    bit          m_done [8];
    bit          m_mis  [8];
    logic [4:0]  m_rd   [8];
    logic [31:0] m_val  [8];
    logic [31:0] m_tgt  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_q(input int t);
        foreach (m_q[i]) if (m_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Model update on each rising edge from the values presented before it
    always @(posedge clk) begin
        bit rdy;
        bit cv;
        if (!clear) begin
            m_q.delete();
            m_tail  = 0;
            m_flush = 1'b0;
            m_redir = 32'h0;
            for (int i = 0; i < 8; i++) begin
                m_done[i] = 1'b0;
                m_mis[i]  = 1'b0;
            end
            m_init = 1'b1;
        end else if (m_init) begin
            rdy = (m_q.size() < 8) && !m_flush;
            cv  = (m_q.size() > 0) && m_done[m_q[0]];
            if (cv && m_mis[m_q[0]]) begin
                m_redir = m_tgt[m_q[0]];
                m_q.delete();
                m_tail  = 0;
                m_flush = 1'b1;
            end else begin
                m_flush = 1'b0;
                if (cdbValid && in_q(int'(cdbRob))) begin
                    m_done[cdbRob] = 1'b1;
                    m_mis[cdbRob]  = cdbMispredict;
                    m_val[cdbRob]  = cdbResult;
                    m_tgt[cdbRob]  = cdbTarget;
                end
                if (cv) void'(m_q.pop_front());
                if (dispatchValid && rdy) begin
                    m_q.push_back(m_tail);
                    m_rd[m_tail]   = dispatchRd;
                    m_done[m_tail] = 1'b0;
                    m_mis[m_tail]  = 1'b0;
                    m_tail         = (m_tail + 1) % 8;
                end
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        bit          e_cv;
        int          e_head;
        bit          e_sr;
        logic [31:0] e_sv;
        if (m_init) begin
            e_cv   = (m_q.size() > 0) && m_done[m_q[0]];
            e_head = (m_q.size() > 0) ? m_q[0] : m_tail;
            if (in_q(int'(srcRob)) && m_done[srcRob]) begin
                e_sr = 1'b1; e_sv = m_val[srcRob];
            end else if (cdbValid && cdbRob == srcRob) begin
                e_sr = 1'b1; e_sv = cdbResult;
            end else begin
                e_sr = 1'b0; e_sv = 32'h0;
            end
            chk("m_dispatchReady", dispatchReady, (m_q.size() < 8) && !m_flush);
            chk("m_dispatchRob", dispatchRob, m_tail);
            chk("m_commitValid", commitValid, e_cv);
            chk("m_commitRob", commitRob, e_head);
            if (e_cv) begin
                chk("m_commitRd", commitRd, m_rd[e_head]);
                chk("m_commitValue", commitValue, m_val[e_head]);
            end
            chk("m_flush", flush, m_flush);
            if (m_flush) chk("m_redirectPC", redirectPC, m_redir);
            chk("m_srcReady", srcReady, e_sr);
            chk("m_srcValue", srcValue, e_sv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        dispatchValid = 1'b0;
        cdbValid      = 1'b0;
        cdbMispredict = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        clear = 1'b0;
        tick();
        clear = 1'b1;
    endtask

    task automatic dispatch(input logic [4:0] rd);
        dispatchValid = 1'b1;
        dispatchRd    = rd;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] res,
                       input logic mis, input logic [31:0] tgt);
        cdbValid      = 1'b1;
        cdbRob        = tag;
        cdbResult     = res;
        cdbMispredict = mis;
        cdbTarget     = tgt;
    endtask

    initial begin
        clear = 1'b0; dispatchValid = 1'b0; dispatchRd = 5'd0;
        cdbValid = 1'b0; cdbRob = 3'd0; cdbResult = 32'd0;
        cdbMispredict = 1'b0; cdbTarget = 32'd0; srcRob = 3'd0;

        // Reset values
        tick(); tick(); #2;
        chk("rst_dispatchReady", dispatchReady, 32'd1);
        chk("rst_dispatchRob", dispatchRob, 32'd0);
        chk("rst_commitValid", commitValid, 32'd0);
        chk("rst_commitRd", commitRd, 32'd0);
        chk("rst_commitValue", commitValue, 32'd0);
        chk("rst_flush", flush, 32'd0);
        chk("rst_redirectPC", redirectPC, 32'd0);
        chk("rst_srcReady", srcReady, 32'd0);
        clear = 1'b1;

        // Basic retire two cycles after allocation
        tick(); dispatch(5'd5); #2;
        chk("basic_allocRob", dispatchRob, 32'd0);
        tick(); cdb(3'd0, 32'd60, 1'b0, 32'd0); #2;
        chk("basic_noEarlyCommit", commitValid, 32'd0);
        tick(); #2;
        chk("basic_commitValid", commitValid, 32'd1);
        chk("basic_commitRd", commitRd, 32'd5);
        chk("basic_commitValue", commitValue, 32'd60);
        chk("basic_commitRob", commitRob, 32'd0);
        tick(); #2;
        chk("basic_retired", commitValid, 32'd0);

        // Out-of-order writeback, in-order retirement
        do_reset();
        for (int i = 0; i < 3; i++) begin tick(); dispatch(5'(i + 1)); end
        for (int i = 2; i >= 0; i--) begin tick(); cdb(3'(i), 32'(10 * (i + 1)), 1'b0, 32'd0); end
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            chk("ooo_commitValid", commitValid, 32'd1);
            chk("ooo_commitRob", commitRob, 32'(i));
            chk("ooo_commitValue", commitValue, 32'(10 * (i + 1)));
        end

        // Full, refused dispatch, wrap and simultaneous allocate/commit at count 7
        do_reset();
        for (int i = 0; i < 8; i++) begin tick(); dispatch(5'(i + 1)); end
        tick(); dispatch(5'd9); cdb(3'd0, 32'd100, 1'b0, 32'd0); #2;
        chk("full_ready", dispatchReady, 32'd0);
        chk("full_rob", dispatchRob, 32'd0);
        tick(); dispatch(5'd9); cdb(3'd1, 32'd101, 1'b0, 32'd0); #2;
        chk("full_commitRefuse", dispatchReady, 32'd0);
        chk("full_commitRob", commitRob, 32'd0);
        tick(); dispatch(5'd20); #2;
        chk("wrap_ready7", dispatchReady, 32'd1);
        chk("wrap_rob", dispatchRob, 32'd0);
        chk("wrap_commitRob", commitRob, 32'd1);
        tick(); dispatch(5'd21); #2;
        chk("both_ready", dispatchReady, 32'd1);
        chk("both_tail", dispatchRob, 32'd1);
        chk("both_head", commitRob, 32'd2);
        tick(); #2;
        chk("refull_ready", dispatchReady, 32'd0);

        // Mispredicted branch retires, younger entries squashed
        do_reset();
        for (int i = 0; i < 4; i++) begin tick(); dispatch(5'(i + 1)); end
        tick(); cdb(3'd1, 32'h11, 1'b1, 32'h100);
        tick(); cdb(3'd0, 32'h5, 1'b0, 32'h0);
        tick(); cdb(3'd2, 32'h6, 1'b0, 32'h0); #2;
        chk("mis_commit0", commitRob, 32'd0);
        tick(); cdb(3'd3, 32'h7, 1'b0, 32'h0); #2;
        chk("mis_commit1", commitRob, 32'd1);
        chk("mis_commit1v", commitValid, 32'd1);
        tick(); dispatch(5'd9); #2;
        chk("mis_flush", flush, 32'd1);
        chk("mis_redirect", redirectPC, 32'h100);
        chk("mis_readyLow", dispatchReady, 32'd0);
        chk("mis_noCommit", commitValid, 32'd0);
        tick(); dispatch(5'd3); #2;
        chk("mis_flushDone", flush, 32'd0);
        chk("mis_tag0", dispatchRob, 32'd0);
        tick(); #2;
        chk("mis_tag1next", dispatchRob, 32'd1);
        chk("mis_squashed", commitValid, 32'd0);

        // Operand lookup with same-cycle bypass then stored value
        do_reset();
        for (int i = 0; i < 4; i++) begin tick(); dispatch(5'(i + 1)); end
        tick(); srcRob = 3'd3; #2;
        chk("src_pending", srcReady, 32'd0);
        chk("src_pendingVal", srcValue, 32'd0);
        tick(); cdb(3'd3, 32'd77, 1'b0, 32'd0); #2;
        chk("src_bypass", srcReady, 32'd1);
        chk("src_bypassVal", srcValue, 32'd77);
        tick(); #2;
        chk("src_stored", srcReady, 32'd1);
        chk("src_storedVal", srcValue, 32'd77);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
